// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA text writer.
//   COLS / ROWS   : text grid size (80 x 30)
//   BLANK         : character code written when clearing
//   CH_BS/LF/CR/FF: control codes interpreted by the writer
//   state_t       : writer FSM state encoding
package vga_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUT     = 2'd1,
        CLR_ROW = 2'd2,
        CLR_ALL = 2'd3
    } state_t;

endpackage

// File: rtl/vga_text_writer.sv
// vga_text_writer: turns a stream of character/control codes into writes to
// a text-mode video memory and tracks the cursor.
//
// Ports:
//   clk50_in   : single clock, everything on its rising edge
//   rst        : synchronous active-high reset
//   char_in    : character or control code
//   char_valid : char_in valid
//   char_ready : writer accepts a character this cycle (IDLE only)
//   vmem_addr  : write address, x | (y << 7)
//   vmem_data  : write data
//   vmem_we    : write strobe, one write per asserted cycle
//   cursor_x   : current column 0..COLS-1
//   cursor_y   : current row 0..ROWS-1
//
// Handshake: a character transfers on a rising edge where char_valid and
// char_ready are both 1. char_in is ignored while char_ready is 0; the
// producer holds char_valid/char_in stable until the transfer happens.
//
// After reset the whole screen is blanked (CLR_ALL) before the first
// character can be accepted.
module vga_text_writer #(
    parameter int         COLS  = vga_pkg::COLS,
    parameter int         ROWS  = vga_pkg::ROWS,
    parameter logic [7:0] BLANK = vga_pkg::BLANK
) (
    input  logic        clk50_in,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [11:0] vmem_addr,
    output logic [7:0]  vmem_data,
    output logic        vmem_we,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);

    import vga_pkg::*;

    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    state_t     state, state_n;
    logic [6:0] cur_x, cur_x_n;
    logic [4:0] cur_y, cur_y_n;
    // Shared address generator: holds the PUT target or the clear position.
    logic [6:0] ax, ax_n;
    logic [4:0] ay, ay_n;
    logic [7:0] data_q, data_n;
    // PUT advances the cursor for a printed character, not for a backspace.
    logic       adv_q, adv_n;
    logic [4:0] y_next;

    assign y_next = (cur_y == LAST_Y) ? 5'd0 : cur_y + 5'd1;

    always_ff @(posedge clk50_in) begin
        if (rst) begin
            state  <= CLR_ALL;
            cur_x  <= 7'd0;
            cur_y  <= 5'd0;
            ax     <= 7'd0;
            ay     <= 5'd0;
            data_q <= BLANK;
            adv_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cur_x  <= cur_x_n;
            cur_y  <= cur_y_n;
            ax     <= ax_n;
            ay     <= ay_n;
            data_q <= data_n;
            adv_q  <= adv_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_x_n = cur_x;
        cur_y_n = cur_y;
        ax_n    = ax;
        ay_n    = ay;
        data_n  = data_q;
        adv_n   = adv_q;
        unique case (state)
            IDLE: begin
                if (char_valid) begin
                    case (char_in)
                        CH_LF: begin
                            cur_x_n = 7'd0;
                            cur_y_n = y_next;
                            ax_n    = 7'd0;
                            ay_n    = y_next;
                            state_n = CLR_ROW;
                        end
                        CH_CR: begin
                            cur_x_n = 7'd0;
                        end
                        CH_BS: begin
                            // At column 0 a backspace is a no-op.
                            if (cur_x != 7'd0) begin
                                cur_x_n = cur_x - 7'd1;
                                ax_n    = cur_x - 7'd1;
                                ay_n    = cur_y;
                                data_n  = BLANK;
                                adv_n   = 1'b0;
                                state_n = PUT;
                            end
                        end
                        CH_FF: begin
                            ax_n    = 7'd0;
                            ay_n    = 5'd0;
                            state_n = CLR_ALL;
                        end
                        default: begin
                            ax_n    = cur_x;
                            ay_n    = cur_y;
                            data_n  = char_in;
                            adv_n   = 1'b1;
                            state_n = PUT;
                        end
                    endcase
                end
            end
            PUT: begin
                state_n = IDLE;
                if (adv_q) begin
                    if (cur_x == LAST_X) begin
                        // Line full: wrap and blank the next row.
                        cur_x_n = 7'd0;
                        cur_y_n = y_next;
                        ax_n    = 7'd0;
                        ay_n    = y_next;
                        state_n = CLR_ROW;
                    end else begin
                        cur_x_n = cur_x + 7'd1;
                    end
                end
            end
            CLR_ROW: begin
                if (ax == LAST_X) begin
                    state_n = IDLE;
                end else begin
                    ax_n = ax + 7'd1;
                end
            end
            CLR_ALL: begin
                if (ax == LAST_X) begin
                    ax_n = 7'd0;
                    if (ay == LAST_Y) begin
                        state_n = IDLE;
                        cur_x_n = 7'd0;
                        cur_y_n = 5'd0;
                    end else begin
                        ay_n = ay + 5'd1;
                    end
                end else begin
                    ax_n = ax + 7'd1;
                end
            end
        endcase
    end

    // rst gates every output directly so a reset aborts in the same cycle,
    // before the registers have been reloaded.
    assign char_ready = !rst && (state == IDLE);
    assign vmem_we    = !rst && (state != IDLE);
    assign vmem_addr  = rst ? 12'd0 : {ay, ax};
    assign vmem_data  = (!rst && state == PUT) ? data_q : BLANK;
    assign cursor_x   = rst ? 7'd0 : cur_x;
    assign cursor_y   = rst ? 5'd0 : cur_y;

endmodule

// File: tb/tb_vga_text_writer.sv
module tb_vga_text_writer;

    logic        clk50_in = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [11:0] vmem_addr;
    logic [7:0]  vmem_data;
    logic        vmem_we;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    int n_tests = 0;
    int n_fail  = 0;

    // reference cursor
    int m_x = 0;
    int m_y = 0;

    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    typedef struct {
        logic [7:0] ch;
        int         exp_x;
        int         exp_y;
        int         exp_writes;
    } vec_t;

    vga_text_writer dut (
        .clk50_in  (clk50_in),
        .rst       (rst),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .vmem_addr (vmem_addr),
        .vmem_data (vmem_data),
        .vmem_we   (vmem_we),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    // ---------------- clock ----------------
    always #10 clk50_in = ~clk50_in;

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk50_in) begin
        if (vmem_we) begin
            got_q.push_back({vmem_addr, vmem_data});
            if (rst) begin
                n_fail++;
                $display("FAIL write_in_reset: addr=%h data=%h, required no write", vmem_addr, vmem_data);
            end
            if (char_ready) begin
                n_fail++;
                $display("FAIL ready_while_busy: char_ready=1 during write, required 0");
            end
            if (vmem_addr[6:0] >= 7'd80 || vmem_addr[11:7] >= 5'd30) begin
                n_fail++;
                $display("FAIL addr_range: addr=%h, required col<80 row<30", vmem_addr);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [19:0] ent(input int x, input int y, input int d);
        int a;
        a = x + 128 * y;
        return {12'(a), 8'(d)};
    endfunction

    task automatic model_row_clear(input int y);
        for (int x = 0; x < 80; x++) exp_q.push_back(ent(x, y, 32));
    endtask

    task automatic model_char(input logic [7:0] c);
        case (c)
            8'h0A: begin
                m_x = 0;
                m_y = (m_y + 1) % 30;
                model_row_clear(m_y);
            end
            8'h0D: m_x = 0;
            8'h08: begin
                if (m_x > 0) begin
                    m_x = m_x - 1;
                    exp_q.push_back(ent(m_x, m_y, 32));
                end
            end
            8'h0C: begin
                for (int y = 0; y < 30; y++) model_row_clear(y);
                m_x = 0;
                m_y = 0;
            end
            default: begin
                exp_q.push_back(ent(m_x, m_y, int'(c)));
                m_x = m_x + 1;
                if (m_x == 80) begin
                    m_x = 0;
                    m_y = (m_y + 1) % 30;
                    model_row_clear(m_y);
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic send_char(input logic [7:0] c);
        int k;
        char_in = c;
        char_valid = 1'b1;
        k = 0;
        while (!char_ready && k < 3000) begin
            @(negedge clk50_in);
            k++;
        end
        if (!char_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: char %h not accepted within 3000 cycles", c);
        end
        @(posedge clk50_in);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk50_in);
        while (!char_ready && k < 3000) begin
            @(negedge clk50_in);
            k++;
        end
        if (!char_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: char_ready still 0 after 3000 cycles");
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_writes(input string name);
        int n;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         name, i, got_q[i][19:8], got_q[i][7:0], exp_q[i][19:8], exp_q[i][7:0]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cursor(input string name);
        n_tests++;
        if (int'(cursor_x) != m_x || int'(cursor_y) != m_y) begin
            n_fail++;
            $display("FAIL %s_cursor: got (%0d,%0d), required (%0d,%0d)", name, cursor_x, cursor_y, m_x, m_y);
        end
    endtask

    task automatic do_char(input logic [7:0] c, input string name);
        model_char(c);
        send_char(c);
        wait_idle();
        check_writes(name);
        check_cursor(name);
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (vmem_we !== 1'b0 || char_ready !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd0 ||
            vmem_addr !== 12'd0 || vmem_data !== 8'h20) begin
            n_fail++;
            $display("FAIL %s: we=%b ready=%b cur=(%0d,%0d) addr=%h data=%h, required 0 0 (0,0) 000 20",
                     name, vmem_we, char_ready, cursor_x, cursor_y, vmem_addr, vmem_data);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs[13];
        logic [7:0] others[4];
        logic [7:0] c;
        int r;

        vecs[0]  = '{8'h0D, 0, 0, 0};
        vecs[1]  = '{8'h42, 1, 0, 1};
        vecs[2]  = '{8'h43, 2, 0, 1};
        vecs[3]  = '{8'h08, 1, 0, 1};
        vecs[4]  = '{8'h0D, 0, 0, 0};
        vecs[5]  = '{8'h08, 0, 0, 0};
        vecs[6]  = '{8'h0A, 0, 1, 80};
        vecs[7]  = '{8'h7A, 1, 1, 1};
        vecs[8]  = '{8'h7E, 2, 1, 1};
        vecs[9]  = '{8'h01, 3, 1, 1};
        vecs[10] = '{8'hFF, 4, 1, 1};
        vecs[11] = '{8'h0C, 0, 0, 2400};
        vecs[12] = '{8'h20, 1, 0, 1};
        others = '{8'h00, 8'h1B, 8'h80, 8'hFF};

        // reset
        rst = 1'b1;
        char_in = 8'h00;
        char_valid = 1'b0;
        repeat (3) @(negedge clk50_in);
        check_reset_outputs("reset_state");
        @(posedge clk50_in);
        #1;
        rst = 1'b0;

        // power-up clear
        m_x = 0;
        m_y = 0;
        for (int y = 0; y < 30; y++) model_row_clear(y);
        wait_idle();
        check_writes("init_clear");
        check_cursor("init_clear");

        // 'A' at (0,0): write lands exactly one cycle after acceptance
        model_char(8'h41);
        send_char(8'h41);
        @(negedge clk50_in);
        n_tests++;
        if (vmem_we !== 1'b1 || vmem_addr !== 12'h000 || vmem_data !== 8'h41) begin
            n_fail++;
            $display("FAIL put_latency: we=%b addr=%h data=%h, required 1 000 41", vmem_we, vmem_addr, vmem_data);
        end
        wait_idle();
        check_writes("put_A");
        check_cursor("put_A");

        // table-driven vectors
        for (int i = 0; i < 13; i++) begin
            model_char(vecs[i].ch);
            send_char(vecs[i].ch);
            wait_idle();
            n_tests++;
            if (got_q.size() != vecs[i].exp_writes) begin
                n_fail++;
                $display("FAIL vec%0d_nwrites: got %0d, required %0d", i, got_q.size(), vecs[i].exp_writes);
            end
            n_tests++;
            if (int'(cursor_x) != vecs[i].exp_x || int'(cursor_y) != vecs[i].exp_y) begin
                n_fail++;
                $display("FAIL vec%0d_cursor: got (%0d,%0d), required (%0d,%0d)",
                         i, cursor_x, cursor_y, vecs[i].exp_x, vecs[i].exp_y);
            end
            check_writes($sformatf("vec%0d", i));
        end

        // 80 'x' from (0,5): line wrap + blank of row 6
        do_char(8'h0D, "to_row5_cr");
        for (int i = 0; i < 5; i++) do_char(8'h0A, "to_row5_lf");
        for (int i = 0; i < 80; i++) begin
            model_char(8'h78);
            send_char(8'h78);
            wait_idle();
        end
        n_tests++;
        if (got_q.size() != 160) begin
            n_fail++;
            $display("FAIL wrap_nwrites: got %0d, required 160", got_q.size());
        end else begin
            n_tests++;
            if (got_q[79] !== {12'h2CF, 8'h78}) begin
                n_fail++;
                $display("FAIL wrap_last_char: got %h, required 2cf78", got_q[79]);
            end
            n_tests++;
            if (got_q[80] !== {12'h300, 8'h20} || got_q[159] !== {12'h34F, 8'h20}) begin
                n_fail++;
                $display("FAIL wrap_row_blank: got %h..%h, required 30020..34f20", got_q[80], got_q[159]);
            end
        end
        check_writes("wrap80");
        n_tests++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd6) begin
            n_fail++;
            $display("FAIL wrap_cursor: got (%0d,%0d), required (0,6)", cursor_x, cursor_y);
        end

        // LF at row 29 wraps to row 0
        for (int i = 0; i < 23; i++) do_char(8'h0A, "to_row29");
        check_cursor("at_row29");
        model_char(8'h0A);
        send_char(8'h0A);
        wait_idle();
        n_tests++;
        if (got_q.size() != 80 || got_q[0] !== {12'h000, 8'h20} || got_q[79] !== {12'h04F, 8'h20}) begin
            n_fail++;
            $display("FAIL lf_wrap_blank: got %0d writes, required 80 blanks 000..04f", got_q.size());
        end
        check_writes("lf_wrap");
        n_tests++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            n_fail++;
            $display("FAIL lf_wrap_cursor: got (%0d,%0d), required (0,0)", cursor_x, cursor_y);
        end

        // BS at (3,2) and at (0,2)
        do_char(8'h0A, "bs_setup");
        do_char(8'h0A, "bs_setup");
        do_char(8'h61, "bs_setup");
        do_char(8'h62, "bs_setup");
        do_char(8'h63, "bs_setup");
        model_char(8'h08);
        send_char(8'h08);
        wait_idle();
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== {12'h102, 8'h20}) begin
            n_fail++;
            $display("FAIL bs_write: got %0d writes, required one blank at 102", got_q.size());
        end
        check_writes("bs_mid");
        n_tests++;
        if (cursor_x !== 7'd2 || cursor_y !== 5'd2) begin
            n_fail++;
            $display("FAIL bs_cursor: got (%0d,%0d), required (2,2)", cursor_x, cursor_y);
        end
        do_char(8'h0D, "bs_cr");
        do_char(8'h08, "bs_col0");

        // reset during CLR_ROW with char_valid held high
        send_char(8'h0A);
        char_in = 8'h51;
        char_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk50_in);
            n_tests++;
            if (char_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready: char_ready=%b, required 0", char_ready);
            end
        end
        @(posedge clk50_in);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50_in);
            check_reset_outputs("mid_reset");
        end
        n_tests++;
        if (got_q.size() < 10 || got_q.size() > 12) begin
            n_fail++;
            $display("FAIL partial_clear: got %0d writes before reset, required 10..12", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
        @(posedge clk50_in);
        #1;
        rst = 1'b0;
        m_x = 0;
        m_y = 0;
        for (int y = 0; y < 30; y++) model_row_clear(y);
        model_char(8'h51);
        send_char(8'h51);
        wait_idle();
        check_writes("reset_reclear");
        check_cursor("reset_reclear");

        // randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 8'($urandom_range(32, 126));
            else if (r < 70) c = 8'h0A;
            else if (r < 78) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else if (r < 99) c = others[$urandom_range(0, 3)];
            else             c = 8'h0C;
            do_char(c, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter BLANK, default 8'h20, character code written when clearing.
REQ-004 SHALL have port clk50_in, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port char_in, input, 8, character or control code from the CPU display data register.
REQ-007 SHALL have port char_valid, input, 1, char_in valid.
REQ-008 SHALL have port char_ready, output, 1, writer can accept a character this cycle.
REQ-009 SHALL have port vmem_addr, output, 12, video memory write address.
REQ-010 SHALL have port vmem_data, output, 8, video memory write data.
REQ-011 SHALL have port vmem_we, output, 1, video memory write strobe, one write per asserted cycle.
REQ-012 SHALL have port cursor_x, output, 7, current column, 0..COLS-1.
REQ-013 SHALL have port cursor_y, output, 5, current row, 0..ROWS-1.

Function
REQ-014 SHALL form every address as vmem_addr = x | (y << 7), matching the display scan-out mapping.
REQ-015 SHALL implement states IDLE, PUT, CLR_ROW and CLR_ALL.
REQ-016 SHALL assert char_ready only in IDLE; a character is accepted on a cycle with char_valid & char_ready.
REQ-017 SHALL leave char_in unsampled while char_ready=0; the producer holds char_valid and char_in stable until accepted.
REQ-018 For printable codes 0x20..0x7E (and any code not listed below): SHALL enter PUT and, on the cycle after acceptance, assert vmem_we for one cycle with addr(cursor) and data=char_in; then cursor_x+1.
REQ-019 When cursor_x+1 == COLS after a PUT: SHALL set cursor_x=0, advance the row, and enter CLR_ROW.
REQ-020 For 0x0A (LF): SHALL set cursor_x=0, advance the row, enter CLR_ROW, and perform no character write.
REQ-021 For 0x0D (CR): SHALL set cursor_x=0, perform no write, and return to IDLE on the next cycle.
REQ-022 For 0x08 (BS) with cursor_x>0: SHALL decrement cursor_x, then write BLANK at the new position through PUT without advancing.
REQ-023 For 0x08 with cursor_x==0: SHALL perform no write and make no cursor change.
REQ-024 For 0x0C (FF): SHALL enter CLR_ALL and, on completion, home the cursor to (0,0).
REQ-025 Row advance: SHALL set y+1, wrapping ROWS-1 to 0; there is no scrolling.
REQ-026 CLR_ROW: SHALL write BLANK to columns 0..COLS-1 of the new row, one per cycle, 80 consecutive vmem_we cycles, then return to IDLE.
REQ-027 CLR_ALL: SHALL write BLANK to rows 0..ROWS-1, columns 0..COLS-1, row-major, one per cycle (2400 cycles), then return to IDLE.
REQ-028 SHALL never drive addresses with column >= COLS or row >= ROWS.
REQ-029 SHALL hold vmem_we=0 in IDLE.
REQ-030 SHALL change cursor outputs only at the state transitions defined above.

Reset
REQ-031 While rst=1: SHALL force vmem_we=0, char_ready=0, cursor (0,0), vmem_addr=0 and vmem_data=BLANK.
REQ-032 On the first cycle after rst deasserts: SHALL enter CLR_ALL, so that memory is blanked before the first character is accepted.
REQ-033 rst asserted mid-operation, in any state: SHALL abort immediately with no further writes, then follow REQ-032.

Structure
REQ-034 SHALL place COLS, ROWS, BLANK, the control codes (BS, LF, CR, FF) and the state encoding in a shared package, vga_pkg.
REQ-035 SHALL keep a single module; the clear counter and the PUT path share one address generator, and no sub-module is required.

Verification
REQ-036 Reset, then wait: SHALL show exactly 2400 vmem_we pulses of 0x20 covering x 0..79 and y 0..29, followed by char_ready=1 and cursor (0,0).
REQ-037 Send 'A' at (0,0): SHALL show one vmem_we with addr 0x000 and data 0x41 one cycle after acceptance, then cursor (1,0).
REQ-038 Send 80 'x' characters from (0,5): SHALL show the last write at addr 0x2CF, then 80 blanks at 0x300..0x34F, then cursor (0,6).
REQ-039 Send LF at row 29: SHALL wrap the cursor to (0,0) and blank 0x000..0x04F; no character is written.
REQ-040 Send BS at (3,2) and at (0,2): SHALL produce a blank at 0x102 with cursor (2,2) for the first, and no write with no cursor change for the second.
REQ-041 Assert rst during CLR_ROW and hold char_valid high throughout busy states: SHALL show no acceptance while busy, no writes while rst=1, and a full clear after release.
